// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch control plane.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2,
    SW_LAP   = 2'd3
  } sw_state_t;

  // Bits needed to hold a prescaler count of 0..tick_div-1.
  function automatic int unsigned tick_div_w(input int unsigned tick_div);
    return (tick_div < 2) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Synchronises and debounces one raw push-button, producing a filtered level
// and a single-cycle pulse on each accepted rising edge.
module btn_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic rise_pulse_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Count while the synchronised level disagrees with the filtered one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_lvl != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = sync_lvl;
        rise_d  = sync_lvl;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level_o      = level_q;
  assign rise_pulse_o = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control plane: button conditioning, 10 Hz tick prescaler and the
// IDLE/RUN/PAUSE/LAP mode FSM. Define STOPWATCH_LAP_EN to enable the LAP mode.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       tick_10hz,
  output logic       count_en,
  output logic       count_clr,
  output logic       display_freeze,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned TICK_W   = tick_div_w(TICK_DIV);

  localparam logic [1:0] ST_IDLE  = SW_IDLE;
  localparam logic [1:0] ST_RUN   = SW_RUN;
  localparam logic [1:0] ST_PAUSE = SW_PAUSE;
  localparam logic [1:0] ST_LAP   = SW_LAP;

  logic              start_p, clear_p;
  logic              start_lvl, clear_lvl;
  logic              unused_levels;
  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              en_q, en_d;
  logic              clr_q, clr_d;
  logic              frz_q, frz_d;
  logic              run_q, run_d;

  btn_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_btn (
    .clk         (clk),
    .reset       (reset),
    .btn_i       (btn_start_stop),
    .level_o     (start_lvl),
    .rise_pulse_o(start_p)
  );

  btn_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_btn (
    .clk         (clk),
    .reset       (reset),
    .btn_i       (btn_clear),
    .level_o     (clear_lvl),
    .rise_pulse_o(clear_p)
  );

  // Only the edge pulses drive the FSM; the filtered levels are not needed here.
  assign unused_levels = start_lvl ^ clear_lvl;

  // Mode sequencing; start wins in RUN/LAP, clear wins in IDLE/PAUSE.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_p) begin
          clr_d = 1'b1;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (start_p) begin
          state_d = ST_PAUSE;
        end
`ifdef STOPWATCH_LAP_EN
        else if (clear_p) begin
          state_d = ST_LAP;
        end
`endif
      end
      ST_PAUSE: begin
        if (clear_p) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (start_p) begin
          state_d = ST_RUN;
        end
      end
      ST_LAP: begin
`ifdef STOPWATCH_LAP_EN
        if (start_p) begin
          state_d = ST_PAUSE;
        end else if (clear_p) begin
          state_d = ST_RUN;
        end
`else
        state_d = ST_IDLE;
`endif
      end
    endcase
  end

  // Prescaler and registered output decode, aligned with the next state.
  always_comb begin
    presc_d = '0;
    if (!clr_d && (presc_q != TICK_W'(TICK_DIV - 1))) begin
      presc_d = presc_q + TICK_W'(1);
    end
    tick_d = (presc_d == TICK_W'(TICK_DIV - 1));
    run_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    en_d   = tick_d && run_d;
`ifdef STOPWATCH_LAP_EN
    frz_d  = (state_d == ST_LAP);
`else
    frz_d  = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      frz_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      frz_q   <= frz_d;
      run_q   <= run_d;
    end
  end

  assign tick_10hz      = tick_q;
  assign count_en       = en_q;
  assign count_clr      = clr_q;
  assign display_freeze = frz_q;
  assign running        = run_q;
  assign state          = state_q;

endmodule
